// File: rtl/microtile_seq_counter.sv
// ---------------------------------------------------------------------------
// microtile_seq_counter
//
// Small multi-mode sequence counter for a micro tile. It counts up, counts
// down, holds, or steps a maximal-length Fibonacci LFSR. A prescaler divides
// the step rate by 2^PRESCALE enabled cycles. A synchronous load
// overrides everything else.
//
// Parameters
//   WIDTH    : counter width, legal 3..7 (default 7)
//   PRESCALE : counter steps once every 2^PRESCALE enabled cycles,
//              legal 0..4 (default 0)
//
// Ports
//   clk    : single clock, all state updates on its rising edge
//   rst_n  : asynchronous active-low reset, clears all state
//   ena    : tile enable, all state holds while low
//   ui_in  : [1:0] mode (00 hold, 01 up, 10 down, 11 LFSR)
//            [2]   load strobe
//            [7:3] load value (zero-extended or truncated to WIDTH)
//   uo_out : [WIDTH-1:0] count, [6:WIDTH] zero, [7] wrap pulse
//
// Configuration macro
//   MICROTILE_SYNC_INPUT_EN : when defined, ui_in passes through a 2-flop
//   synchroniser before decode (2 extra cycles of latency). When undefined,
//   ui_in is sampled directly and the latency to uo_out is one clock.
// ---------------------------------------------------------------------------
module microtile_seq_counter #(
    parameter int WIDTH    = 7,
    parameter int PRESCALE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LFSR = 2'b11
    } mode_t;

    // LFSR tap position t (1-based): fb = count[WIDTH-1] ^ count[t-1].
    // Each pair gives a primitive trinomial so the period from 1 is
    // 2^WIDTH-1.
    localparam int TAP = (WIDTH == 3) ? 2 :
                         (WIDTH == 4) ? 3 :
                         (WIDTH == 5) ? 3 :
                         (WIDTH == 6) ? 5 : 6;

    // The prescaler register is at least one bit wide so the PRESCALE=0
    // build still has a legal vector; in that case it is held at zero.
    localparam int              PW      = (PRESCALE > 0) ? PRESCALE : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'((1 << PRESCALE) - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [7:0]       in_s;
    mode_t            mode;
    logic             load;
    logic [WIDTH-1:0] load_val;

    logic [PW-1:0]    prescaler;
    logic [PW-1:0]    prescaler_next;
    logic             strobe;

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic             wrap;
    logic             wrap_next;

    logic             fb;
    logic [WIDTH-1:0] lfsr_next;

    // -----------------------------------------------------------------------
    // Input stage. With the synchroniser enabled both flops follow the tile
    // enable so that a disabled tile keeps every bit of its state.
    // -----------------------------------------------------------------------
`ifdef MICROTILE_SYNC_INPUT_EN
    logic [7:0] sync_q1;
    logic [7:0] sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else if (ena) begin
            sync_q1 <= ui_in;
            sync_q2 <= sync_q1;
        end
    end

    assign in_s = sync_q2;
`else
    assign in_s = ui_in;
`endif

    // -----------------------------------------------------------------------
    // Decode. The 5-bit load field is zero-extended for WIDTH above 5 and
    // truncated (upper bits dropped) for WIDTH below 5.
    // -----------------------------------------------------------------------
    assign mode = mode_t'(in_s[1:0]);
    assign load = in_s[2];

    for (genvar i = 0; i < WIDTH; i++) begin : g_load_val
        if (i < 5) begin : g_field
            assign load_val[i] = in_s[3+i];
        end else begin : g_pad
            assign load_val[i] = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Prescaler. Free-runs on ena, wraps to 0 after PS_LAST, and is cleared
    // by a load so the first step after a load lands 2^PRESCALE enabled
    // cycles later. A mode change does not touch it.
    // -----------------------------------------------------------------------
    assign strobe = ena && (prescaler == PS_LAST);

    always_comb begin
        prescaler_next = prescaler;
        if (ena) begin
            if (load || (PRESCALE == 0)) begin
                prescaler_next = '0;
            end else begin
                prescaler_next = prescaler + PW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // LFSR next value. An all-zero count would lock the shift register, so
    // zero steps to 1 instead.
    // -----------------------------------------------------------------------
    assign fb        = count[WIDTH-1] ^ count[TAP-1];
    assign lfsr_next = (count == '0) ? CNT_ONE : {count[WIDTH-2:0], fb};

    // -----------------------------------------------------------------------
    // Count / wrap next state. Load beats mode and strobe. Wrap marks the
    // step that closes a cycle: up max->0, down 0->max, or the LFSR
    // returning to 1 from a nonzero value (the lock-up escape is not a wrap).
    // While the tile is disabled wrap holds together with the rest.
    // -----------------------------------------------------------------------
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (!ena) begin
            wrap_next = wrap;
        end else if (load) begin
            count_next = load_val;
        end else if (strobe) begin
            case (mode)
                MODE_HOLD: begin
                    count_next = count;
                end
                MODE_UP: begin
                    count_next = count + CNT_ONE;
                    wrap_next  = (count == CNT_MAX);
                end
                MODE_DOWN: begin
                    count_next = count - CNT_ONE;
                    wrap_next  = (count == '0);
                end
                MODE_LFSR: begin
                    count_next = lfsr_next;
                    wrap_next  = (count != '0) && (lfsr_next == CNT_ONE);
                end
                default: begin
                    count_next = count;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            wrap      <= 1'b0;
            prescaler <= '0;
        end else begin
            count     <= count_next;
            wrap      <= wrap_next;
            prescaler <= prescaler_next;
        end
    end

    // -----------------------------------------------------------------------
    // Output packing, straight from registers. Bits between the count field
    // and the wrap bit read as zero for narrow counters.
    // -----------------------------------------------------------------------
    if (WIDTH < 7) begin : g_out_pad
        assign uo_out = {wrap, {(7-WIDTH){1'b0}}, count};
    end else begin : g_out_full
        assign uo_out = {wrap, count};
    end

endmodule

// File: tb/tb_microtile_seq_counter.sv
// ---------------------------------------------------------------------------
// tb_microtile_seq_counter
//
// Drives two counters from the same stimulus: one with PRESCALE=0 and one
// with PRESCALE=2, both WIDTH=7. A behavioural model predicts every cycle of
// both outputs, and directed expectations taken from the requirement
// examples are queued alongside. Queue entries carry the cycle on which the
// output is due and are compared right after that cycle's rising edge.
// ---------------------------------------------------------------------------
module tb_microtile_seq_counter;

`ifdef MICROTILE_SYNC_INPUT_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo0;
    logic [7:0] uo2;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] exp;
        int         due;
    } sb_item_t;

    sb_item_t sb[$];

    // model state: index 0 -> PRESCALE=0, index 1 -> PRESCALE=2
    int         m_cnt[2];
    int         m_ps[2];
    logic       m_wrap[2];
    logic [7:0] m_s1;
    logic [7:0] m_s2;

    microtile_seq_counter #(.WIDTH(7), .PRESCALE(0)) dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo0)
    );

    microtile_seq_counter #(.WIDTH(7), .PRESCALE(2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%02h expected 0x%02h",
                     tag, cyc, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_ps[d]   = 0;
            m_wrap[d] = 1'b0;
        end
        m_s1 = 8'h00;
        m_s2 = 8'h00;
    endtask

    // Queue a directed expectation for the next drive plus 'delay' cycles.
    task automatic expectAt(input string tag, input int dut,
                            input logic [7:0] val, input int delay);
        sb_item_t it;
        it.tag = tag;
        it.dut = dut;
        it.exp = val;
        it.due = cyc + 1 + delay;
        sb.push_back(it);
    endtask

    task automatic modelStep(input logic [7:0] ui, input logic en);
        logic [7:0] eff;
        int         last;
        int         n;
        logic       stb;
        sb_item_t   it;
        eff = (EXTRA > 0) ? m_s2 : ui;
        if (en) begin
            for (int d = 0; d < 2; d++) begin
                last = (d == 0) ? 0 : 3;
                if (eff[2]) begin
                    m_cnt[d]  = int'(eff[7:3]);
                    m_ps[d]   = 0;
                    m_wrap[d] = 1'b0;
                end else begin
                    stb      = (m_ps[d] == last);
                    m_ps[d]  = (m_ps[d] == last) ? 0 : m_ps[d] + 1;
                    m_wrap[d] = 1'b0;
                    if (stb) begin
                        case (eff[1:0])
                            2'b01: begin
                                m_wrap[d] = (m_cnt[d] == 127);
                                m_cnt[d]  = (m_cnt[d] + 1) % 128;
                            end
                            2'b10: begin
                                m_wrap[d] = (m_cnt[d] == 0);
                                m_cnt[d]  = (m_cnt[d] + 127) % 128;
                            end
                            2'b11: begin
                                if (m_cnt[d] == 0) begin
                                    m_cnt[d] = 1;
                                end else begin
                                    n = ((m_cnt[d] << 1) & 127) |
                                        (((m_cnt[d] >> 6) ^ (m_cnt[d] >> 5)) & 1);
                                    m_wrap[d] = (n == 1);
                                    m_cnt[d]  = n;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = ui;
        end
        for (int d = 0; d < 2; d++) begin
            it.tag = (d == 0) ? "model_ps0" : "model_ps2";
            it.dut = d;
            it.exp = {m_wrap[d], 7'(m_cnt[d])};
            it.due = cyc;
            sb.push_back(it);
        end
    endtask

    task automatic drainDue();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checkOutput(sb[i].tag, (sb[i].dut == 0) ? uo0 : uo2, sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] ui, input logic en);
        @(negedge clk);
        ui_in = ui;
        ena   = en;
        cyc++;
        modelStep(ui, en);
        @(posedge clk);
        #1;
        drainDue();
    endtask

    initial begin
        logic [127:0] seen;
        int           distinct;
        logic [7:0]   ur;
        logic [7:0]   rst_vals[6];

        checks = 0;
        errors = 0;
        cyc    = 0;
        seen   = '0;
        modelReset();

        // Reset held with all inputs high: outputs must read zero.
        rst_n = 1'b0;
        ena   = 1'b1;
        ui_in = 8'hFF;
        #1;
        checkOutput("reset_ps0", uo0, 8'h00);
        checkOutput("reset_ps2", uo2, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_clk_ps0", uo0, 8'h00);
            checkOutput("reset_clk_ps2", uo2, 8'h00);
        end
        @(negedge clk);
        ui_in = 8'h00;
        ena   = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            expectAt("post_reset", 0, 8'h00, 0);
            applyStimulus(8'h00, 1'b1);
        end

        // Load 0x1F then count up.
        expectAt("load_1f", 0, 8'h1F, EXTRA);
        applyStimulus(8'hFC, 1'b1);
        expectAt("up_20", 0, 8'h20, EXTRA);
        applyStimulus(8'h01, 1'b1);
        expectAt("up_21", 0, 8'h21, EXTRA);
        applyStimulus(8'h01, 1'b1);
        expectAt("up_22", 0, 8'h22, EXTRA);
        applyStimulus(8'h01, 1'b1);

        // Load 0 then count down through the wrap.
        expectAt("load_0", 0, 8'h00, EXTRA);
        applyStimulus(8'h04, 1'b1);
        expectAt("down_wrap", 0, 8'hFF, EXTRA);
        applyStimulus(8'h02, 1'b1);
        expectAt("down_7e", 0, 8'h7E, EXTRA);
        applyStimulus(8'h02, 1'b1);
        expectAt("hold_7e", 0, 8'h7E, EXTRA);
        applyStimulus(8'h00, 1'b1);
        for (int i = 0; i < EXTRA; i++) begin
            applyStimulus(8'h00, 1'b1);
        end

        // LFSR from 0: escape to 1, then one full period back to 1.
        expectAt("lfsr_load0", 0, 8'h00, EXTRA);
        applyStimulus(8'h04, 1'b1);
        expectAt("lfsr_01", 0, 8'h01, EXTRA);
        applyStimulus(8'h03, 1'b1);
        for (int i = 1; i <= 127 + EXTRA; i++) begin
            if (i == 1)   expectAt("lfsr_02", 0, 8'h02, EXTRA);
            if (i == 2)   expectAt("lfsr_04", 0, 8'h04, EXTRA);
            if (i == 127) expectAt("lfsr_wrap", 0, 8'h81, EXTRA);
            applyStimulus(8'h03, 1'b1);
            if (i >= 1 + EXTRA) seen[uo0[6:0]] = 1'b1;
        end
        distinct = 0;
        for (int v = 1; v < 128; v++) begin
            if (seen[v]) distinct++;
        end
        checkOutput("lfsr_distinct", 8'(distinct), 8'd127);

        // Prescaled counter: steps every 4th enabled cycle, freezes with ena.
        expectAt("ps_load0", 1, 8'h00, EXTRA);
        applyStimulus(8'h04, 1'b1);
        for (int k = 1; k <= 6 + EXTRA; k++) begin
            if (k <= 6) expectAt("ps_up", 1, (k >= 4) ? 8'h01 : 8'h00, EXTRA);
            applyStimulus(8'h01, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            expectAt("ps_frozen", 1, 8'h01, 0);
            applyStimulus(8'h01, 1'b0);
        end
        rst_vals = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03};
        for (int k = 0; k < 6; k++) begin
            expectAt("ps_resume", 1, rst_vals[k], 0);
            applyStimulus(8'h01, 1'b1);
        end

        // Reset pulsed mid-count clears outputs at once, without a clock.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ena   = 1'b0;
        #1;
        checkOutput("midreset_ps0", uo0, 8'h00);
        checkOutput("midreset_ps2", uo2, 8'h00);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(8'h01, 1'b1);
        end

        // Random traffic checked against the model.
        for (int i = 0; i < 300; i++) begin
            ur = 8'($urandom);
            if ($urandom_range(0, 7) != 0) ur[2] = 1'b0;
            applyStimulus(ur, ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 1'b1);
        end
        checkOutput("scoreboard_empty", 8'(sb.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
